l2_mesi_directory: RTL



---
 rtl/l2_mesi_directory_if.sv | 32 +++
 rtl/l2_mesi_directory.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_mesi_directory_if.sv
// L1-side request / response channel of the L2 MESI directory.
// master: the L1 request port; slave: the directory itself.
interface l2_mesi_directory_if #(
  parameter int ADDR_W   = 32,
  parameter int WAY_W    = 3,
  parameter int TAG_BITS = 12
);
  logic                req_valid;
  logic                req_ready;
  logic [2:0]          req_op;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_shared;
  logic                rsp_valid;
  logic                rsp_hit;
  logic [WAY_W-1:0]    rsp_way;
  logic [1:0]          rsp_mesi;
  logic [2:0]          rsp_bus_op;
  logic                rsp_evict;
  logic [TAG_BITS-1:0] rsp_evict_tag;

  modport master (
    output req_valid, req_op, req_addr, req_shared,
    input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_bus_op,
           rsp_evict, rsp_evict_tag
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_shared,
    output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_mesi, rsp_bus_op,
           rsp_evict, rsp_evict_tag
  );
endinterface

// File: rtl/l2_mesi_directory.sv
// L2 MESI directory: tag, MESI and true-LRU state for a WAYS-way cache with
// 2^INDEX_BITS sets. One request at a time, INIT -> IDLE -> LOOKUP -> UPDATE.
// Optional feature macro: L2_STATS_EN adds saturating CPU hit/miss counters.
module l2_mesi_directory #(
  parameter int WAYS        = 8,
  parameter int INDEX_BITS  = 14,
  parameter int TAG_BITS    = 12,
  parameter int OFFSET_BITS = 6,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef L2_STATS_EN
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] miss_count_o,
`endif
  l2_mesi_directory_if.slave bus
);
  localparam int ADDR_W = TAG_BITS + INDEX_BITS + OFFSET_BITS;
  localparam int WAY_W  = $clog2(WAYS);
  localparam int SETS   = 1 << INDEX_BITS;

  localparam logic [1:0] ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_LOOKUP = 2'd2, ST_UPDATE = 2'd3;
  localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
  localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_RFO = 3'd2,
                         BUS_UPGRADE = 3'd3, BUS_WB = 3'd4;
  localparam logic [2:0] OP_CPU_RD = 3'd0, OP_CPU_WR = 3'd1, OP_SNP_RD = 3'd2,
                         OP_SNP_RFO = 3'd3, OP_SNP_INV = 3'd4;

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] init_idx_q;
  logic [2:0]            req_op_q;
  logic [TAG_BITS-1:0]   req_tag_q;
  logic [INDEX_BITS-1:0] req_idx_q;
  logic                  req_shared_q;

  logic [TAG_BITS-1:0]   tag_mem_q  [SETS][WAYS];
  logic [1:0]            mesi_mem_q [SETS][WAYS];
  logic [WAY_W-1:0]      age_mem_q  [SETS][WAYS];

  // Pending array write, decided in LOOKUP and committed at the end of UPDATE.
  logic                  wr_line_q, wr_line_d, wr_lru_q, wr_lru_d;
  logic [1:0]            wr_mesi_q, wr_mesi_d;
  logic [WAY_W-1:0]      wr_age_q [WAYS];
  logic [WAY_W-1:0]      wr_age_d [WAYS];

  logic                  rsp_hit_q, rsp_hit_d, rsp_evict_q, rsp_evict_d;
  logic [WAY_W-1:0]      rsp_way_q, rsp_way_d;
  logic [1:0]            rsp_mesi_q, rsp_mesi_d;
  logic [2:0]            rsp_bus_op_q, rsp_bus_op_d;
  logic [TAG_BITS-1:0]   rsp_evict_tag_q, rsp_evict_tag_d;

  logic                  hit, has_inv;
  logic [WAY_W-1:0]      hit_way, inv_way, lru_way, victim, acc_way;
  logic [1:0]            old_mesi, vic_mesi;
  logic                  unused_offset;

  assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_UPDATE);
  assign bus.rsp_hit       = rsp_hit_q;
  assign bus.rsp_way       = rsp_way_q;
  assign bus.rsp_mesi      = rsp_mesi_q;
  assign bus.rsp_bus_op    = rsp_bus_op_q;
  assign bus.rsp_evict     = rsp_evict_q;
  assign bus.rsp_evict_tag = rsp_evict_tag_q;

  // Tag match, first invalid way and LRU way of the addressed set.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    lru_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && mesi_mem_q[req_idx_q][w] != MESI_I && tag_mem_q[req_idx_q][w] == req_tag_q) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!has_inv && mesi_mem_q[req_idx_q][w] == MESI_I) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_mem_q[req_idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim   = has_inv ? inv_way : lru_way;
    acc_way  = hit ? hit_way : victim;
    old_mesi = mesi_mem_q[req_idx_q][hit_way];
    vic_mesi = mesi_mem_q[req_idx_q][victim];
  end

  // MESI transition, bus operation and eviction for the latched request.
  always_comb begin
    rsp_hit_d       = 1'b0;
    rsp_way_d       = '0;
    rsp_mesi_d      = MESI_I;
    rsp_bus_op_d    = BUS_NONE;
    rsp_evict_d     = 1'b0;
    rsp_evict_tag_d = '0;
    wr_line_d       = 1'b0;
    wr_lru_d        = 1'b0;
    wr_mesi_d       = MESI_I;
    case (req_op_q)
      OP_CPU_RD, OP_CPU_WR: begin
        wr_lru_d  = 1'b1;
        wr_line_d = 1'b1;
        rsp_way_d = acc_way;
        if (hit) begin
          rsp_hit_d = 1'b1;
          if (req_op_q == OP_CPU_RD) begin
            rsp_mesi_d = old_mesi;
          end else begin
            rsp_mesi_d   = MESI_M;
            rsp_bus_op_d = (old_mesi == MESI_S) ? BUS_UPGRADE : BUS_NONE;
          end
        end else begin
          if (req_op_q == OP_CPU_RD) begin
            rsp_mesi_d   = req_shared_q ? MESI_S : MESI_E;
            rsp_bus_op_d = BUS_READ;
          end else begin
            rsp_mesi_d   = MESI_M;
            rsp_bus_op_d = BUS_RFO;
          end
          rsp_evict_d = (vic_mesi == MESI_M);
          if (vic_mesi == MESI_M) rsp_evict_tag_d = tag_mem_q[req_idx_q][victim];
        end
        wr_mesi_d = rsp_mesi_d;
      end
      OP_SNP_RD, OP_SNP_RFO, OP_SNP_INV: begin
        if (hit) begin
          rsp_hit_d    = 1'b1;
          rsp_way_d    = hit_way;
          rsp_mesi_d   = (req_op_q == OP_SNP_RD) ? MESI_S : MESI_I;
          rsp_bus_op_d = (old_mesi == MESI_M) ? BUS_WB : BUS_NONE;
          wr_line_d    = 1'b1;
          wr_mesi_d    = rsp_mesi_d;
        end
      end
      default: ;
    endcase
  end

  // True-LRU ages after touching acc_way.
  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        wr_age_d[w] = '0;
      else if (age_mem_q[req_idx_q][w] < age_mem_q[req_idx_q][acc_way])
        wr_age_d[w] = age_mem_q[req_idx_q][w] + WAY_W'(1);
      else
        wr_age_d[w] = age_mem_q[req_idx_q][w];
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (init_idx_q == INDEX_BITS'(SETS - 1)) state_d = ST_IDLE;
      ST_IDLE:   if (bus.req_valid) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control, request latch and response registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q         <= ST_INIT;
      init_idx_q      <= '0;
      req_op_q        <= '0;
      req_tag_q       <= '0;
      req_idx_q       <= '0;
      req_shared_q    <= 1'b0;
      wr_line_q       <= 1'b0;
      wr_lru_q        <= 1'b0;
      wr_mesi_q       <= MESI_I;
      for (int w = 0; w < WAYS; w++) wr_age_q[w] <= '0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_mesi_q      <= MESI_I;
      rsp_bus_op_q    <= BUS_NONE;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_idx_q <= init_idx_q + INDEX_BITS'(1);
      if (state_q == ST_IDLE && bus.req_valid) begin
        req_op_q     <= bus.req_op;
        req_tag_q    <= bus.req_addr[ADDR_W-1 -: TAG_BITS];
        req_idx_q    <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
        req_shared_q <= bus.req_shared;
      end
      if (state_q == ST_LOOKUP) begin
        wr_line_q       <= wr_line_d;
        wr_lru_q        <= wr_lru_d;
        wr_mesi_q       <= wr_mesi_d;
        wr_age_q        <= wr_age_d;
        rsp_hit_q       <= rsp_hit_d;
        rsp_way_q       <= rsp_way_d;
        rsp_mesi_q      <= rsp_mesi_d;
        rsp_bus_op_q    <= rsp_bus_op_d;
        rsp_evict_q     <= rsp_evict_d;
        rsp_evict_tag_q <= rsp_evict_tag_d;
      end
    end
  end

  // Directory array: swept clean by INIT, written once per request in UPDATE.
  always_ff @(posedge clk) begin
    // NOTE: the arrays have no reset branch; the INIT sweep clears them, keeping them plain RAM.
    if (!rst) begin
      if (state_q == ST_INIT) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_mem_q[init_idx_q][w]  <= '0;
          mesi_mem_q[init_idx_q][w] <= MESI_I;
          age_mem_q[init_idx_q][w]  <= WAY_W'(w);
        end
      end else if (state_q == ST_UPDATE) begin
        if (wr_line_q) begin
          tag_mem_q[req_idx_q][rsp_way_q]  <= req_tag_q;
          mesi_mem_q[req_idx_q][rsp_way_q] <= wr_mesi_q;
        end
        if (wr_lru_q)
          for (int w = 0; w < WAYS; w++) age_mem_q[req_idx_q][w] <= wr_age_q[w];
      end
    end
  end

`ifdef L2_STATS_EN
  logic [CNT_W-1:0] hit_count_q, miss_count_q;
  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;

  // Saturating CPU hit/miss counters, stepped once per completed CPU request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == ST_UPDATE && (req_op_q == OP_CPU_RD || req_op_q == OP_CPU_WR)) begin
      if (rsp_hit_q && hit_count_q != '1)   hit_count_q  <= hit_count_q + CNT_W'(1);
      if (!rsp_hit_q && miss_count_q != '1) miss_count_q <= miss_count_q + CNT_W'(1);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule
